// File: rtl/vram_scroll_ctrl_pkg.sv
// vram_scroll_ctrl shared definitions
// text VRAM geometry and engine state encoding
package vram_scroll_ctrl_pkg;

   localparam int ROW_WORDS   = 40;
   localparam int ROWS        = 30;
   localparam int ADDR_W      = 11;
   localparam int VRAM_WORDS  = ROW_WORDS * ROWS;
   localparam int SCROLL_LAST = VRAM_WORDS - ROW_WORDS - 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_CAP,
      ST_WR,
      ST_FILL,
      ST_FIN
   } state_e;

endpackage

// File: rtl/vram_scroll_ctrl_if.sv
// vram_scroll_ctrl bus bundle
// host Avalon-MM slave side plus VRAM port A
interface vram_scroll_ctrl_if #(
   parameter int ADDR_W = vram_scroll_ctrl_pkg::ADDR_W
);

   logic              AVL_CS;
   logic              AVL_READ;
   logic              AVL_WRITE;
   logic [3:0]        AVL_BYTE_EN;
   logic [ADDR_W-1:0] AVL_ADDR;
   logic [31:0]       AVL_WRITEDATA;
   logic [31:0]       AVL_READDATA;

   logic [ADDR_W-1:0] RAM_ADDR;
   logic [3:0]        RAM_BYTEEN;
   logic [31:0]       RAM_WDATA;
   logic              RAM_RDEN;
   logic              RAM_WREN;
   logic [31:0]       RAM_Q;

   modport slave (
      input  AVL_CS, AVL_READ, AVL_WRITE,
      input  AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
      output AVL_READDATA,
      output RAM_ADDR, RAM_BYTEEN, RAM_WDATA,
      output RAM_RDEN, RAM_WREN,
      input  RAM_Q
   );

   modport master (
      output AVL_CS, AVL_READ, AVL_WRITE,
      output AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
      input  AVL_READDATA,
      input  RAM_ADDR, RAM_BYTEEN, RAM_WDATA,
      input  RAM_RDEN, RAM_WREN,
      output RAM_Q
   );

endinterface

// File: rtl/vram_scroll_ctrl.sv
// VRAM scroll/clear engine and port-A arbiter
// host always owns port A; engine runs in host-idle cycles
module vram_scroll_ctrl #(
   parameter int ROW_WORDS = vram_scroll_ctrl_pkg::ROW_WORDS,
   parameter int ROWS      = vram_scroll_ctrl_pkg::ROWS,
   parameter int ADDR_W    = vram_scroll_ctrl_pkg::ADDR_W
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              CMD_SCROLL,
   input  logic              CMD_CLEAR,
   input  logic [31:0]       FILL_WORD,
   output logic              BUSY,
   output logic              DONE,
   vram_scroll_ctrl_if.slave bus
);

   import vram_scroll_ctrl_pkg::*;

   localparam logic [ADDR_W-1:0] ROW_OFS =
      ADDR_W'(ROW_WORDS);
   localparam logic [ADDR_W-1:0] SCROLL_END =
      ADDR_W'(ROW_WORDS * (ROWS - 1) - 1);
   localparam logic [ADDR_W-1:0] BOTTOM =
      ADDR_W'(ROW_WORDS * (ROWS - 1));
   localparam logic [ADDR_W-1:0] FILL_END =
      ADDR_W'(ROW_WORDS * ROWS - 1);
   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [31:0]       data_q, data_d;
   logic [31:0]       fill_q, fill_d;
   logic [ADDR_W-1:0] src;
   logic              host;
   logic              src_hit;

   assign host    = bus.AVL_CS & (bus.AVL_READ | bus.AVL_WRITE);
   assign src     = idx_q + ROW_OFS;
   // a host write to the word we are moving makes the copy stale
   assign src_hit = bus.AVL_CS & bus.AVL_WRITE
                  & (bus.AVL_ADDR == src);

   assign bus.AVL_READDATA = bus.RAM_Q;

   // state, index, data and fill-pattern registers
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         data_q  <= '0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         fill_q  <= fill_d;
      end
   end

   // next-state: RD/WR/FILL wait for host-idle, CAP never waits
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      fill_d  = fill_q;
      unique case (state_q)
         ST_IDLE: begin
            if (CMD_CLEAR) begin
               state_d = ST_FILL;
               idx_d   = '0;
               fill_d  = FILL_WORD;
            end else if (CMD_SCROLL) begin
               state_d = ST_RD;
               idx_d   = '0;
               fill_d  = FILL_WORD;
            end
         end
         ST_RD: begin
            if (!host) state_d = ST_CAP;
         end
         ST_CAP: begin
            data_d  = bus.RAM_Q;
            state_d = src_hit ? ST_RD : ST_WR;
         end
         ST_WR: begin
            if (src_hit) begin
               state_d = ST_RD;
            end else if (!host) begin
               if (idx_q == SCROLL_END) begin
                  state_d = ST_FILL;
                  idx_d   = BOTTOM;
               end else begin
                  state_d = ST_RD;
                  idx_d   = idx_q + ONE;
               end
            end
         end
         ST_FILL: begin
            if (!host) begin
               if (idx_q == FILL_END) state_d = ST_FIN;
               else idx_d = idx_q + ONE;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // outputs: status flags and the port-A mux
   always_comb begin
      BUSY           = (state_q != ST_IDLE) && (state_q != ST_FIN);
      DONE           = (state_q == ST_FIN);
      bus.RAM_ADDR   = '0;
      bus.RAM_BYTEEN = '0;
      bus.RAM_WDATA  = '0;
      bus.RAM_RDEN   = 1'b0;
      bus.RAM_WREN   = 1'b0;
      if (host) begin
         bus.RAM_ADDR   = bus.AVL_ADDR;
         bus.RAM_BYTEEN = bus.AVL_BYTE_EN;
         bus.RAM_WDATA  = bus.AVL_WRITEDATA;
         bus.RAM_RDEN   = bus.AVL_READ;
         bus.RAM_WREN   = bus.AVL_WRITE;
      end else begin
         unique case (state_q)
            ST_RD: begin
               bus.RAM_ADDR   = src;
               bus.RAM_BYTEEN = 4'hF;
               bus.RAM_RDEN   = 1'b1;
            end
            ST_WR: begin
               bus.RAM_ADDR   = idx_q;
               bus.RAM_BYTEEN = 4'hF;
               bus.RAM_WDATA  = data_q;
               bus.RAM_WREN   = 1'b1;
            end
            ST_FILL: begin
               bus.RAM_ADDR   = idx_q;
               bus.RAM_BYTEEN = 4'hF;
               bus.RAM_WDATA  = fill_q;
               bus.RAM_WREN   = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vram_scroll_ctrl.sv
// vram_scroll_ctrl bench
// directed scroll/clear runs against a port-A RAM model
module tb_vram_scroll_ctrl;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        CMD_SCROLL;
   logic        CMD_CLEAR;
   logic [31:0] FILL_WORD;
   logic        BUSY;
   logic        DONE;

   int n_chk = 0;
   int n_bad = 0;

   logic [31:0] mem    [0:2047];
   logic [31:0] expmem [0:1199];

   vram_scroll_ctrl_if #(.ADDR_W(11)) bus ();

   vram_scroll_ctrl dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .CMD_SCROLL (CMD_SCROLL),
      .CMD_CLEAR  (CMD_CLEAR),
      .FILL_WORD  (FILL_WORD),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .bus        (bus.slave)
   );

   always #10 CLK = ~CLK;

   // port-A RAM: byte-enabled write, registered read
   always @(posedge CLK) begin
      if (bus.RAM_WREN)
         for (int b = 0; b < 4; b++)
            if (bus.RAM_BYTEEN[b])
               mem[bus.RAM_ADDR][8*b +: 8] <= bus.RAM_WDATA[8*b +: 8];
      if (bus.RAM_RDEN) bus.RAM_Q <= mem[bus.RAM_ADDR];
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic hidle();
      bus.AVL_CS        = 1'b0;
      bus.AVL_READ      = 1'b0;
      bus.AVL_WRITE     = 1'b0;
      bus.AVL_BYTE_EN   = 4'h0;
      bus.AVL_ADDR      = '0;
      bus.AVL_WRITEDATA = '0;
   endtask

   task automatic hwr(input int a, input logic [31:0] d,
                      input logic [3:0] be);
      bus.AVL_CS        = 1'b1;
      bus.AVL_READ      = 1'b0;
      bus.AVL_WRITE     = 1'b1;
      bus.AVL_BYTE_EN   = be;
      bus.AVL_ADDR      = 11'(a);
      bus.AVL_WRITEDATA = d;
   endtask

   task automatic hrd(input int a);
      bus.AVL_CS        = 1'b1;
      bus.AVL_READ      = 1'b1;
      bus.AVL_WRITE     = 1'b0;
      bus.AVL_BYTE_EN   = 4'hF;
      bus.AVL_ADDR      = 11'(a);
      bus.AVL_WRITEDATA = '0;
   endtask

   task automatic preload();
      for (int n = 0; n < 1200; n++) begin
         @(negedge CLK);
         hwr(n, 32'(n), 4'hF);
      end
      @(negedge CLK);
      hidle();
   endtask

   // pulse commands; returns at the negedge one cycle after acceptance
   task automatic fire(input bit scr, input bit clr,
                       input logic [31:0] fw);
      @(negedge CLK);
      CMD_SCROLL = scr;
      CMD_CLEAR  = clr;
      FILL_WORD  = fw;
      @(negedge CLK);
      CMD_SCROLL = 1'b0;
      CMD_CLEAR  = 1'b0;
      FILL_WORD  = ~fw;
   endtask

   // mode 0: idle host, 1: host every other cycle, 2: coherency script
   task automatic wait_done(input int mode, input bit poke,
                            output int cyc, output bit busy_ok);
      int h;
      cyc     = 1;
      busy_ok = 1'b1;
      while (!DONE && cyc < 8000) begin
         if (!BUSY) busy_ok = 1'b0;
         hidle();
         CMD_SCROLL = poke && (cyc == 100);
         if (mode == 1 && cyc[0]) begin
            h = (cyc - 1) / 2;
            if (h >= 20 && !h[0]) begin
               hwr(h / 2, 32'hC0DE0000 | 32'(h), 4'hF);
               expmem[h / 2] = 32'hC0DE0000 | 32'(h);
            end else begin
               hrd(h);
            end
         end
         if (mode == 2) begin
            case (cyc)
               5:  hwr(41, 32'hDEADBEEF, 4'hF);
               20: hrd(600);
               21: begin
                  chk("rd600", bus.AVL_READDATA, 32'd600);
                  hrd(41);
               end
               22: chk("rd41", bus.AVL_READDATA, 32'hDEADBEEF);
               30: hrd(0);
               31: chk("rd0", bus.AVL_READDATA, 32'd40);
               40: hrd(1);
               41: chk("rd1", bus.AVL_READDATA, 32'hDEADBEEF);
               default: ;
            endcase
         end
         @(negedge CLK);
         cyc++;
      end
      hidle();
      CMD_SCROLL = 1'b0;
      chk("done_seen", 32'(DONE), 32'd1);
      @(negedge CLK);
      chk("done_pulse", 32'(DONE), 32'd0);
      chk("busy_low", 32'(BUSY), 32'd0);
   endtask

   task automatic cmp_mem(input string tag);
      int errs = 0;
      for (int i = 0; i < 1200; i++)
         if (mem[i] !== expmem[i]) errs++;
      chk(tag, 32'(errs), 32'd0);
   endtask

   initial begin
      int  cyc;
      bit  bok;
      int  nd;

      RESET      = 1'b0;
      CMD_SCROLL = 1'b0;
      CMD_CLEAR  = 1'b0;
      FILL_WORD  = '0;
      hidle();
      repeat (3) @(negedge CLK);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_done", 32'(DONE), 32'd0);
      chk("rst_rden", 32'(bus.RAM_RDEN), 32'd0);
      chk("rst_wren", 32'(bus.RAM_WREN), 32'd0);
      chk("rst_addr", 32'(bus.RAM_ADDR), 32'd0);
      chk("rst_wdata", bus.RAM_WDATA, 32'd0);
      chk("rst_be", 32'(bus.RAM_BYTEEN), 32'd0);
      RESET = 1'b1;

      // scroll with idle host
      preload();
      fire(1'b1, 1'b0, 32'h00200020);
      wait_done(0, 1'b0, cyc, bok);
      chk("scr_cyc", 32'(cyc), 32'd3521);
      chk("scr_busy", 32'(bok), 32'd1);
      for (int i = 0; i < 1200; i++)
         expmem[i] = (i < 1160) ? 32'(i + 40) : 32'h00200020;
      cmp_mem("scr_mem");
      chk("scr_w0", mem[0], 32'd40);
      chk("scr_w1159", mem[1159], 32'd1199);
      chk("scr_w1160", mem[1160], 32'h00200020);

      // clear with idle host, fill word changes after acceptance
      fire(1'b0, 1'b1, 32'hA5A5A5A5);
      wait_done(0, 1'b0, cyc, bok);
      chk("clr_cyc", 32'(cyc), 32'd1201);
      chk("clr_busy", 32'(bok), 32'd1);
      for (int i = 0; i < 1200; i++) expmem[i] = 32'hA5A5A5A5;
      cmp_mem("clr_mem");
      @(negedge CLK);
      hwr(5, 32'h12345678, 4'b0011);
      @(negedge CLK);
      hrd(5);
      @(negedge CLK);
      hidle();
      chk("be_rd", bus.AVL_READDATA, 32'hA5A55678);

      // both commands together, plus a scroll poke while busy
      preload();
      fire(1'b1, 1'b1, 32'h0BADF00D);
      wait_done(0, 1'b1, cyc, bok);
      chk("dual_cyc", 32'(cyc), 32'd1201);
      for (int i = 0; i < 1200; i++) expmem[i] = 32'h0BADF00D;
      cmp_mem("dual_mem");
      nd = 0;
      repeat (60) begin
         @(negedge CLK);
         if (DONE) nd++;
      end
      chk("dual_extra_done", 32'(nd), 32'd0);

      // host write to the source word while engine is in CAP
      preload();
      fire(1'b1, 1'b0, 32'h00200020);
      wait_done(2, 1'b0, cyc, bok);
      for (int i = 0; i < 1200; i++)
         expmem[i] = (i < 1160) ? 32'(i + 40) : 32'h00200020;
      expmem[1] = 32'hDEADBEEF;
      cmp_mem("coh_mem");
      chk("coh_w1", mem[1], 32'hDEADBEEF);
      chk("coh_w41", mem[41], 32'd81);

      // clear with host access every other cycle
      for (int i = 0; i < 1200; i++) expmem[i] = 32'h11111111;
      fire(1'b0, 1'b1, 32'h11111111);
      wait_done(1, 1'b0, cyc, bok);
      chk("alt_cyc", 32'(cyc), 32'd2401);
      cmp_mem("alt_mem");
      chk("alt_w10", mem[10], 32'hC0DE0014);

      // reset in the middle of a scroll, then a normal clear
      fire(1'b1, 1'b0, 32'h00200020);
      repeat (499) @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      chk("mid_rst_busy", 32'(BUSY), 32'd0);
      chk("mid_rst_done", 32'(DONE), 32'd0);
      RESET = 1'b1;
      fire(1'b0, 1'b1, 32'h5A5A0F0F);
      wait_done(0, 1'b0, cyc, bok);
      chk("post_rst_cyc", 32'(cyc), 32'd1201);
      for (int i = 0; i < 1200; i++) expmem[i] = 32'h5A5A0F0F;
      cmp_mem("post_rst_mem");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
